// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchronizer followed by a stability filter that
// updates the level only after the input has differed from it for STABLE_CYCLES cycles.
module debounce_channel #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic STABLE   = 1'b0;
    localparam logic SETTLING = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    (* ASYNC_REG = "TRUE" *) logic s1_q;
    (* ASYNC_REG = "TRUE" *) logic s2_q;

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // A single-cycle filter accepts straight from STABLE, so SETTLING is never entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE: begin
                if (s2_q != level_q) begin
                    if (STABLE_CYCLES == 1) begin
                        level_d = s2_q;
                        rise_d  = s2_q;
                        fall_d  = ~s2_q;
                    end else begin
                        state_d = SETTLING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            default: begin
                if (s2_q == level_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    level_d = s2_q;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= sw_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// Debounces N_CH independent switch inputs into clean levels and edge pulses;
// the top only validates parameters and fans channels out.
module switch_debounce #(
    parameter int N_CH          = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw_raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    // The counter must be able to reach STABLE_CYCLES-1 without wrapping.
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << 20) ||
        (64'd1 << CNT_W) < 64'(STABLE_CYCLES)) begin : g_param_err
        $error("switch_debounce: illegal STABLE_CYCLES/CNT_W combination");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .sw_raw(sw_raw[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule
